// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared types and constants for the multiply/divide unit
package mult_div_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } md_state_t;

  localparam int          MD_ITER       = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFFFFFF;

  // Magnitude of an operand; unsigned ops pass the raw value through.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - operand, control and HI/LO bundle between pipeline and multiply/divide unit
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start, op, A, B, hi_we, lo_we, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, A, B, hi_we, lo_we, wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_div_core.sv
// rtl/mult_div_core.sv - one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step
module mult_div_core (
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] rem_sh;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  always_comb begin
    acc_next = acc;
    sum      = '0;
    rem_sh   = '0;
    if (is_div) begin
      rem_sh = {acc[63:32], acc[31]};
      if (rem_sh >= {1'b0, operand}) begin
        sum      = rem_sh - {1'b0, operand};
        acc_next = {sum[31:0], acc[30:0], 1'b1};
      end else begin
        acc_next = {rem_sh[31:0], acc[30:0], 1'b0};
      end
    end else begin
      sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
      acc_next = {sum, acc[31:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit owning HI/LO; FAST_MULT_EN selects a single-cycle multiplier
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input  logic     clk,
  input  logic     reset,
  mult_div_unit_if.slave bus
);

  md_state_t   state, state_next;
  md_op_t      op_in;
  logic        is_div_in, is_signed_in, div0_in;
  logic [31:0] a_mag, b_mag;
  logic [5:0]  cnt;
  logic [63:0] acc, acc_next;
  logic [31:0] opnd;
  logic        is_div_q, neg_res, neg_rem, div0_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;
  logic [31:0] q_fix, r_fix;
  logic [63:0] prod_fix, result;

  assign op_in        = md_op_t'(bus.op);
  assign is_div_in    = (op_in == MD_DIV) || (op_in == MD_DIVU);
  assign is_signed_in = (op_in == MD_MULT) || (op_in == MD_DIV);
  assign a_mag        = md_abs(bus.A, is_signed_in);
  assign b_mag        = md_abs(bus.B, is_signed_in);
  assign div0_in      = is_div_in && (bus.B == 32'd0);

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.done = done_q;
  assign bus.busy = (state != IDLE);

  mult_div_core u_core (
    .is_div   (is_div_q),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (acc_next)
  );

  // Next-state: divide-by-zero skips the iterations; fast multiply never leaves IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (div0_in)        state_next = FINISH;
          else if (is_div_in) state_next = RUN;
          else begin
`ifdef FAST_MULT_EN
            state_next = IDLE;
`else
            state_next = RUN;
`endif
          end
        end
      end
      RUN:     if (cnt == 6'(ITER - 1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Sign correction of the magnitude result; divide-by-zero returns the raw dividend in HI.
  always_comb begin
    q_fix    = neg_res ? -acc[31:0] : acc[31:0];
    r_fix    = neg_rem ? -acc[63:32] : acc[63:32];
    prod_fix = neg_res ? -acc : acc;
    if (div0_q)        result = {acc[63:32], DIV0_QUOTIENT};
    else if (is_div_q) result = {r_fix, q_fix};
    else               result = prod_fix;
  end

`ifdef FAST_MULT_EN
  logic        fast_pend;
  logic [63:0] fast_prod, fast_raw;
  assign fast_raw = {32'd0, a_mag} * {32'd0, b_mag};
`endif

  // Operand capture, iteration, HI/LO update and MTHI/MTLO writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div_q <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef FAST_MULT_EN
      fast_pend <= 1'b0;
      fast_prod <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_div_q <= is_div_in;
            div0_q   <= div0_in;
            neg_res  <= is_signed_in && (bus.A[31] ^ bus.B[31]);
            neg_rem  <= is_signed_in && is_div_in && bus.A[31];
            cnt      <= '0;
            opnd     <= is_div_in ? b_mag : a_mag;
            acc      <= div0_in ? {bus.A, 32'd0} : {32'd0, (is_div_in ? a_mag : b_mag)};
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
        end
        FINISH: begin
          {hi_q, lo_q} <= result;
          done_q       <= 1'b1;
        end
        default: ;
      endcase
`ifdef FAST_MULT_EN
      fast_pend <= (state == IDLE) && bus.start && !is_div_in;
      fast_prod <= (is_signed_in && (bus.A[31] ^ bus.B[31])) ? -fast_raw : fast_raw;
      if (fast_pend) begin
        {hi_q, lo_q} <= fast_prod;
        done_q       <= 1'b1;
      end
`endif
    end
  end

endmodule
